// File: rtl/alu_op_sequencer.sv
// Four-step control sequencer around the ALU bit-operation units: latches operands,
// presents them for a full settle step, captures the 2*DATA_W result into Z and holds it until acked.
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OPSEL_W = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [OPSEL_W-1:0]    opcode,
    input  logic [DATA_W-1:0]     ra_in,
    input  logic [DATA_W-1:0]     rb_in,
    output logic                  ready,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OPSEL_W-1:0]    alu_op,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]     z_lo,
    output logic [DATA_W-1:0]     z_hi,
    output logic                  z_zero,
    output logic                  done,
    input  logic                  ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [DATA_W-1:0]      y_r;
    logic [DATA_W-1:0]      b_r;
    logic [OPSEL_W-1:0]     op_r;
    logic [2*DATA_W-1:0]    z_r;
    logic                   ready_s;
    logic                   done_s;
    logic                   accept_s;
    logic                   capture_s;

    assign accept_s  = (state_r == ST_IDLE) && start;
    assign capture_s = (state_r == ST_T2);

    // State register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; start is only looked at in IDLE and ack only in T3.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_T1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_T1:   state_next_s = ST_T2;
            ST_T2:   state_next_s = ST_T3;
            ST_T3: begin
                if (ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_T3;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        ready_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: ready_s = 1'b1;
            ST_T1:   ready_s = 1'b0;
            ST_T2:   ready_s = 1'b0;
            ST_T3:   done_s  = 1'b1;
            default: begin
                ready_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Y/B/OP holding registers, loaded only on an accepted request.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            y_r  <= {DATA_W{1'b0}};
            b_r  <= {DATA_W{1'b0}};
            op_r <= {OPSEL_W{1'b0}};
        end else if (accept_s) begin
            y_r  <= ra_in;
            b_r  <= rb_in;
            op_r <= opcode;
        end else begin
            y_r  <= y_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    // Z register; the full ALU result is captured unmasked at the end of T2.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z_r <= {(2*DATA_W){1'b0}};
        end else if (capture_s) begin
            z_r <= alu_result;
        end else begin
            z_r <= z_r;
        end
    end

    assign ready  = ready_s;
    assign done   = done_s;
    assign alu_a  = y_r;
    assign alu_b  = b_r;
    assign alu_op = op_r;
    assign z_lo   = z_r[DATA_W-1:0];
    assign z_hi   = z_r[2*DATA_W-1:DATA_W];
    assign z_zero = ~|z_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer; the ALU is modelled as {32'h0, alu_a & alu_b}.
module tb_alu_op_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic [3:0]  opcode;
    logic [31:0] ra_in;
    logic [31:0] rb_in;
    logic        ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic [31:0] z_lo;
    logic [31:0] z_hi;
    logic        z_zero;
    logic        done;
    logic        ack;

    int n_vec;
    int n_miss;

    alu_op_sequencer #(.DATA_W(32), .OPSEL_W(4)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .opcode     (opcode),
        .ra_in      (ra_in),
        .rb_in      (rb_in),
        .ready      (ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .z_lo       (z_lo),
        .z_hi       (z_hi),
        .z_zero     (z_zero),
        .done       (done),
        .ack        (ack)
    );

    assign alu_result = {32'h0000_0000, alu_a & alu_b};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one edge, then drop start.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        start  = 1'b1;
        ra_in  = a;
        rb_in  = b;
        opcode = op;
        tick();
        start  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  {63'd0, ready},  64'd1);
        check({tag, "_done"},   {63'd0, done},   64'd0);
        check({tag, "_alu_a"},  {32'd0, alu_a},  64'd0);
        check({tag, "_alu_b"},  {32'd0, alu_b},  64'd0);
        check({tag, "_alu_op"}, {60'd0, alu_op}, 64'd0);
        check({tag, "_z_lo"},   {32'd0, z_lo},   64'd0);
        check({tag, "_z_hi"},   {32'd0, z_hi},   64'd0);
        check({tag, "_z_zero"}, {63'd0, z_zero}, 64'd1);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        clear  = 1'b0;
        start  = 1'b1;
        ack    = 1'b0;
        opcode = 4'h7;
        ra_in  = $urandom();
        rb_in  = $urandom();

        // Reset held across the edge at 5 ns with start high.
        #2;  check_reset_outputs("rst_a");
        #5;  check_reset_outputs("rst_b");
        ra_in = $urandom();
        rb_in = $urandom();
        #5;  check_reset_outputs("rst_c");
        #2;  start = 1'b0;
        #1;  clear = 1'b1;
        tick();
        check_reset_outputs("rst_after");

        // Single AND with an all-zero result.
        do_start(32'hFFFF_FFFF, 32'h0000_0000, 4'h1);
        check("and1_ready_k",  {63'd0, ready},  64'd0);
        check("and1_alu_a",    {32'd0, alu_a},  64'h0000_0000_FFFF_FFFF);
        check("and1_alu_b",    {32'd0, alu_b},  64'd0);
        check("and1_alu_op",   {60'd0, alu_op}, 64'd1);
        check("and1_done_k",   {63'd0, done},   64'd0);
        tick();
        check("and1_done_k1",  {63'd0, done},   64'd0);
        tick();
        check("and1_done_k2",  {63'd0, done},   64'd1);
        check("and1_z_lo",     {32'd0, z_lo},   64'd0);
        check("and1_z_hi",     {32'd0, z_hi},   64'd0);
        check("and1_z_zero",   {63'd0, z_zero}, 64'd1);
        ack = 1'b1;
        tick();
        check("and1_ready_k3", {63'd0, ready},  64'd1);
        check("and1_done_k3",  {63'd0, done},   64'd0);

        // Back-to-back requests four cycles apart with ack held high.
        do_start(32'h1234_5678, 32'h8765_4321, 4'h2);
        tick();
        tick();
        check("b2b1_done",   {63'd0, done},   64'd1);
        check("b2b1_z_lo",   {32'd0, z_lo},   64'h0000_0000_0224_4220);
        check("b2b1_z_hi",   {32'd0, z_hi},   64'd0);
        check("b2b1_z_zero", {63'd0, z_zero}, 64'd0);
        tick();
        check("b2b1_ready",  {63'd0, ready},  64'd1);
        check("b2b1_z_hold", {32'd0, z_lo},   64'h0000_0000_0224_4220);
        do_start(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'h2);
        tick();
        tick();
        check("b2b2_done",   {63'd0, done},   64'd1);
        check("b2b2_z_lo",   {32'd0, z_lo},   64'd0);
        check("b2b2_z_zero", {63'd0, z_zero}, 64'd1);
        tick();
        check("b2b2_ready",  {63'd0, ready},  64'd1);
        ack = 1'b0;

        // Hold in T3 for ten cycles while start pulses with new operands.
        do_start(32'hA5A5_A5A5, 32'hFFFF_0000, 4'h3);
        tick();
        tick();
        check("hold_done0", {63'd0, done}, 64'd1);
        check("hold_z0",    {32'd0, z_lo}, 64'h0000_0000_A5A5_0000);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            ra_in = $urandom();
            rb_in = $urandom();
            tick();
            check("hold_done",  {63'd0, done},  64'd1);
            check("hold_z_lo",  {32'd0, z_lo},  64'h0000_0000_A5A5_0000);
            check("hold_alu_a", {32'd0, alu_a}, 64'h0000_0000_A5A5_A5A5);
        end

        // ack and start together in T3: back to IDLE, no acceptance on that edge.
        ack   = 1'b1;
        start = 1'b1;
        ra_in = 32'h1111_1111;
        rb_in = 32'h3333_3333;
        opcode = 4'h9;
        tick();
        check("ackst_ready", {63'd0, ready}, 64'd1);
        check("ackst_alu_a", {32'd0, alu_a}, 64'h0000_0000_A5A5_A5A5);
        ack = 1'b0;
        tick();
        start = 1'b0;
        check("ackst_acc_ready", {63'd0, ready},  64'd0);
        check("ackst_acc_alu_a", {32'd0, alu_a},  64'h0000_0000_1111_1111);
        check("ackst_acc_alu_op", {60'd0, alu_op}, 64'd9);
        tick();

        // Asynchronous reset between edges while in T2.
        #2;
        clear = 1'b0;
        #1;
        check_reset_outputs("midrst_a");
        tick();
        check_reset_outputs("midrst_b");
        #2;
        clear = 1'b1;
        tick();
        check("midrst_idle", {63'd0, ready}, 64'd1);

        // Fresh operation after the abort.
        do_start(32'hCAFE_BABE, 32'hFFFF_FFFF, 4'hF);
        tick();
        check("fresh_done_k1", {63'd0, done},   64'd0);
        tick();
        check("fresh_done",    {63'd0, done},   64'd1);
        check("fresh_z_lo",    {32'd0, z_lo},   64'h0000_0000_CAFE_BABE);
        check("fresh_alu_op",  {60'd0, alu_op}, 64'd15);
        ack = 1'b1;
        tick();
        check("fresh_ready",   {63'd0, ready},  64'd1);
        ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
